// File: rtl/patch_stream_3_3_if.sv
// Generic valid/ready stream bundle.
//   data  : payload, W bits
//   valid : producer has a beat on data
//   ready : consumer takes the beat when valid && ready
// master = producer side, slave = consumer side.
interface patch_stream_3_3_if #(
    parameter int W = 16
) ();
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/patch_stream_3_3.sv
// patch_stream_3_3: turns a raster-order pixel stream of one IMG_W x IMG_H
// frame into the stream of every fully-valid 3x3 window (no padding),
// packed MSB-first row-major into a 9*DATA_W PATCH word.
// Ports:
//   CLK        : clock, rising edge
//   rst        : synchronous active-high reset
//   pix        : slave stream, DATA_W pixels in (data/valid/ready)
//   patch      : master stream, 9*DATA_W windows out (data/valid/ready)
//   FRAME_DONE : one-cycle pulse after the last pixel of a frame is accepted
module patch_stream_3_3 #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int DATA_W = 16
) (
    input  logic                  CLK,
    input  logic                  rst,
    patch_stream_3_3_if.slave     pix,
    patch_stream_3_3_if.master    patch,
    output logic                  FRAME_DONE
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int PW = 9 * DATA_W;

    typedef logic [DATA_W-1:0] pix_t;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    pix_t          lb0_q [IMG_W];   // previous row
    pix_t          lb0_d [IMG_W];
    pix_t          lb1_q [IMG_W];   // row before that
    pix_t          lb1_d [IMG_W];
    // Only the two most recent window columns need storage; the third
    // (rightmost) column is formed from the incoming pixel each accept.
    pix_t          hist_q [3][2];
    pix_t          hist_d [3][2];
    pix_t          win    [3][3];
    logic [PW-1:0] patch_q, patch_d;
    logic          patch_valid_q, patch_valid_d;
    logic          frame_done_q, frame_done_d;
    logic          accept, emit, last_col, last_row;

    assign pix.ready   = !patch_valid_q || patch.ready;
    assign patch.data  = patch_q;
    assign patch.valid = patch_valid_q;
    assign FRAME_DONE  = frame_done_q;

    always_comb begin
        accept   = pix.valid && pix.ready;
        last_col = (col_q == CW'(IMG_W - 1));
        last_row = (row_q == RW'(IMG_H - 1));
        emit     = (row_q >= RW'(2)) && (col_q >= CW'(2));

        for (int r = 0; r < 3; r++) begin
            win[r][0] = hist_q[r][0];
            win[r][1] = hist_q[r][1];
        end
        win[0][2] = lb1_q[col_q];
        win[1][2] = lb0_q[col_q];
        win[2][2] = pix.data;

        col_d         = col_q;
        row_d         = row_q;
        lb0_d         = lb0_q;
        lb1_d         = lb1_q;
        hist_d        = hist_q;
        patch_d       = patch_q;
        patch_valid_d = patch_valid_q;
        frame_done_d  = 1'b0;

        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                hist_d[r][0] = win[r][1];
                hist_d[r][1] = win[r][2];
            end
            lb1_d[col_q] = lb0_q[col_q];
            lb0_d[col_q] = pix.data;
            col_d        = last_col ? '0 : col_q + 1'b1;
            if (last_col)
                row_d = last_row ? '0 : row_q + 1'b1;
            frame_done_d  = last_col && last_row;
            patch_valid_d = emit;
            if (emit) begin
                for (int k = 0; k < 9; k++)
                    patch_d[(8 - k) * DATA_W +: DATA_W] = win[k / 3][k % 3];
            end
        end else if (patch.ready) begin
            patch_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            col_q         <= '0;
            row_q         <= '0;
            patch_q       <= '0;
            patch_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            patch_q       <= patch_d;
            patch_valid_q <= patch_valid_d;
            frame_done_q  <= frame_done_d;
        end
    end

    // Pixel storage is never emitted before being rewritten, so it needs no reset.
    always_ff @(posedge CLK) begin
        lb0_q  <= lb0_d;
        lb1_q  <= lb1_d;
        hist_q <= hist_d;
    end
endmodule

// File: tb/tb_patch_stream_3_3.sv
module tb_patch_stream_3_3;
    localparam int DW = 16;
    localparam int PW = 9 * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    patch_stream_3_3_if #(.W(DW)) pix4 ();
    patch_stream_3_3_if #(.W(PW)) pat4 ();
    patch_stream_3_3_if #(.W(DW)) pix8 ();
    patch_stream_3_3_if #(.W(PW)) pat8 ();
    logic fd4, fd8;

    patch_stream_3_3 #(.IMG_W(4), .IMG_H(4), .DATA_W(DW)) dut4 (
        .CLK(clk), .rst(rst), .pix(pix4), .patch(pat4), .FRAME_DONE(fd4));
    patch_stream_3_3 #(.IMG_W(8), .IMG_H(8), .DATA_W(DW)) dut8 (
        .CLK(clk), .rst(rst), .pix(pix8), .patch(pat8), .FRAME_DONE(fd8));

    int          sel;     // 0 drives the 4x4 instance, 1 the 8x8 instance
    logic [DW-1:0] din;
    logic        vld, prdy_drv;
    logic        o_pv, o_prdy, o_fd;
    logic [PW-1:0] o_pd;

    assign pix4.data  = din;
    assign pix8.data  = din;
    assign pix4.valid = vld && (sel == 0);
    assign pix8.valid = vld && (sel == 1);
    assign pat4.ready = prdy_drv;
    assign pat8.ready = prdy_drv;
    assign o_pv   = (sel == 1) ? pat8.valid : pat4.valid;
    assign o_pd   = (sel == 1) ? pat8.data  : pat4.data;
    assign o_prdy = (sel == 1) ? pix8.ready : pix4.ready;
    assign o_fd   = (sel == 1) ? fd8 : fd4;

    int n_tests = 0, n_fail = 0;
    int stim[$];
    logic [PW-1:0] expq[$], obsq[$];
    int acc_cyc[$], fd_cyc[$];
    int first_pv_cyc, fd_cnt, proto_err, timed_out, cyc;

    // Reference: every window of a frame whose bottom-right pixel is at
    // row>=2, col>=2, in raster order, packed row-major MSB first.
    function automatic void add_frame_exp(int w, int h, int base);
        logic [PW-1:0] p;
        for (int r = 2; r < h; r++)
            for (int c = 2; c < w; c++) begin
                p = '0;
                for (int dr = -2; dr <= 0; dr++)
                    for (int dc = -2; dc <= 0; dc++)
                        p = (p << DW) | PW'(16'(stim[base + (r + dr) * w + (c + dc)]));
                expq.push_back(p);
            end
    endfunction

    task automatic do_reset();
        rst = 1'b1; vld = 1'b0; prdy_drv = 1'b1; din = '0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs the stim queue through the selected DUT, collecting transferred
    // patches and recording handshake-rule violations in proto_err.
    task automatic drive(input int vpct, input int rpct, input int stall_n, input int max_cyc);
        int idx = 0, stall = 0, idle = 0;
        bit seen_pv = 0, prev_pv = 0, prev_hold = 0, prev_acc = 0, prev_xfer = 0;
        logic [PW-1:0] prev_pd = '0;
        obsq.delete(); acc_cyc.delete(); fd_cyc.delete();
        fd_cnt = 0; proto_err = 0; timed_out = 0; first_pv_cyc = -1; cyc = 0;
        forever begin
            if (o_fd) begin fd_cnt++; fd_cyc.push_back(cyc); end
            if (o_pv && (!prev_pv || prev_xfer) && !prev_acc) proto_err++;
            if (prev_hold && (!o_pv || o_pd !== prev_pd)) proto_err++;
            if (o_pv && !seen_pv) begin seen_pv = 1; first_pv_cyc = cyc; stall = stall_n; end
            prdy_drv = (stall > 0) ? 1'b0 : ($urandom_range(99) < rpct);
            if (stall > 0) stall--;
            vld = (idx < stim.size()) && ($urandom_range(99) < vpct);
            din = vld ? 16'(stim[idx]) : 16'($urandom);
            #1;
            if (o_prdy !== (!o_pv || prdy_drv)) proto_err++;
            prev_xfer = o_pv && prdy_drv;
            prev_acc  = vld && o_prdy;
            prev_hold = o_pv && !prdy_drv;
            prev_pd   = o_pd;
            prev_pv   = o_pv;
            if (prev_xfer) obsq.push_back(o_pd);
            if (prev_acc) begin acc_cyc.push_back(cyc); idx++; end
            if (idx == stim.size() && !prev_acc) idle++; else idle = 0;
            if (idle >= 4 && (rpct == 0 || !o_pv)) break;
            if (cyc >= max_cyc) begin timed_out = 1; break; end
            @(negedge clk); cyc++;
        end
        vld = 1'b0;
    endtask

    task automatic check_stream(input string name, input int exp_fd);
        n_tests++;
        if (timed_out !== 0) begin n_fail++; $display("FAIL %s timeout: cycle budget expired", name); end
        n_tests++;
        if (proto_err !== 0) begin n_fail++; $display("FAIL %s handshake: %0d violations, want 0", name, proto_err); end
        n_tests++;
        if (obsq.size() !== expq.size()) begin
            n_fail++; $display("FAIL %s count: got %0d patches, want %0d", name, obsq.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
            n_tests++;
            if (obsq[i] !== expq[i]) begin
                n_fail++; $display("FAIL %s patch[%0d]: got %h want %h", name, i, obsq[i], expq[i]);
            end
        end
        n_tests++;
        if (fd_cnt !== exp_fd) begin n_fail++; $display("FAIL %s frame_done: got %0d pulses want %0d", name, fd_cnt, exp_fd); end
    endtask

    task automatic load_ramp(input int base, input int n);
        for (int i = 0; i < n; i++) stim.push_back(base + i);
    endtask

    task automatic test_reset();
        sel = 0;
        do_reset();
        n_tests++;
        if (o_pv !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_pv); end
        n_tests++;
        if (o_pd !== '0) begin n_fail++; $display("FAIL reset_patch: got %h want 0", o_pd); end
        n_tests++;
        if (o_fd !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", o_fd); end
        n_tests++;
        if (o_prdy !== 1'b1) begin n_fail++; $display("FAIL reset_pix_ready: got %b want 1", o_prdy); end
    endtask

    task automatic test_basic();
        sel = 0; do_reset();
        stim.delete(); expq.delete(); load_ramp(0, 16); add_frame_exp(4, 4, 0);
        drive(100, 100, 0, 500);
        check_stream("basic", 1);
        n_tests++;
        if (acc_cyc.size() == 16 && first_pv_cyc !== acc_cyc[10] + 1) begin
            n_fail++; $display("FAIL basic_latency: first patch at %0d want %0d", first_pv_cyc, acc_cyc[10] + 1);
        end
        n_tests++;
        if (fd_cyc.size() == 1 && acc_cyc.size() == 16 && fd_cyc[0] !== acc_cyc[15] + 1) begin
            n_fail++; $display("FAIL basic_done_timing: pulse at %0d want %0d", fd_cyc[0], acc_cyc[15] + 1);
        end
    endtask

    task automatic test_backpressure();
        sel = 0; do_reset();
        stim.delete(); expq.delete(); load_ramp(0, 16); add_frame_exp(4, 4, 0);
        drive(100, 100, 5, 500);
        check_stream("backpressure", 1);
        n_tests++;
        if (acc_cyc.size() == 16 && acc_cyc[11] !== first_pv_cyc + 5) begin
            n_fail++; $display("FAIL bp_resume: pixel 11 at %0d want %0d", acc_cyc[11], first_pv_cyc + 5);
        end
    endtask

    task automatic test_bubbles();
        for (int rep = 0; rep < 3; rep++) begin
            sel = 0; do_reset();
            stim.delete(); expq.delete(); load_ramp(0, 16); add_frame_exp(4, 4, 0);
            drive(50, 60 + 10 * rep, 0, 2000);
            check_stream("bubbles", 1);
        end
    endtask

    task automatic test_back_to_back();
        sel = 0; do_reset();
        stim.delete(); expq.delete();
        load_ramp(0, 16); load_ramp(100, 16);
        add_frame_exp(4, 4, 0); add_frame_exp(4, 4, 16);
        drive(100, 100, 0, 500);
        check_stream("back_to_back", 2);
        n_tests++;
        if (acc_cyc.size() == 32 && acc_cyc[16] !== acc_cyc[15] + 1) begin
            n_fail++; $display("FAIL b2b_gap: next frame pixel at %0d want %0d", acc_cyc[16], acc_cyc[15] + 1);
        end
    endtask

    task automatic test_mid_reset();
        sel = 0; do_reset();
        // Patch ready held low so the window from pixel 10 is still pending at reset.
        stim.delete(); expq.delete(); load_ramp(0, 11);
        drive(100, 0, 0, 200);
        n_tests++;
        if (o_pv !== 1'b1) begin n_fail++; $display("FAIL midreset_pending: got %b want 1", o_pv); end
        rst = 1'b1; prdy_drv = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (o_pv !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b want 0", o_pv); end
        n_tests++;
        if (o_fd !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b want 0", o_fd); end
        stim.delete(); expq.delete(); load_ramp(0, 16); add_frame_exp(4, 4, 0);
        drive(100, 100, 0, 500);
        check_stream("midreset_frame", 1);
    endtask

    task automatic test_default_params();
        logic [PW-1:0] last_exp;
        int last_vals[9] = '{45, 46, 47, 53, 54, 55, 61, 62, 63};
        sel = 1; do_reset();
        stim.delete(); expq.delete();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) stim.push_back(r * 8 + c);
        add_frame_exp(8, 8, 0);
        drive(70, 60, 0, 5000);
        check_stream("default_8x8", 1);
        last_exp = '0;
        for (int k = 0; k < 9; k++) last_exp = (last_exp << DW) | PW'(16'(last_vals[k]));
        n_tests++;
        if (obsq.size() == 0 || obsq[obsq.size() - 1] !== last_exp) begin
            n_fail++;
            $display("FAIL default_last: got %h want %h", (obsq.size() > 0) ? obsq[obsq.size() - 1] : '0, last_exp);
        end
        sel = 0;
    endtask

    initial begin
        sel = 0; rst = 1'b1; vld = 1'b0; prdy_drv = 1'b1; din = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_bubbles();
        test_back_to_back();
        test_mid_reset();
        test_default_params();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
